a_fifo_wr_arb: RTL and testbench

//  Round-robin write-port arbiter in front of the async FIFO write-side pointer controller.

---
 rtl/a_fifo_pkg.sv | 26 ++
 rtl/a_fifo_wr_arb_if.sv | 40 ++++
 rtl/a_fifo_wr_arb_rr_pick.sv | 38 +++
 rtl/a_fifo_wr_arb.sv | 129 ++++++++++++
 tb/tb_a_fifo_wr_arb.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/a_fifo_pkg.sv
// Shared definitions for the async FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state encoding (ST_IDLE / ST_BURST)
//   clog2       : ceiling log2, used to derive index and counter widths
package a_fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int width_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/a_fifo_wr_arb_if.sv
// Bundle between the write-domain producers, the arbiter and the FIFO write
// controller.
//   req        : per-requester write request (data valid while high)
//   wdata      : packed requester data, requester i at [i*DATA_W +: DATA_W]
//   gnt        : one-hot registered grant back to the requesters
//   fifo_full  : registered full flag from the FIFO write controller
//   fifo_inc   : write strobe to the FIFO controller
//   fifo_wdata : data to the FIFO RAM write port
// master = producer/FIFO side, slave = arbiter.
interface a_fifo_wr_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic                      fifo_full;
    logic                      fifo_inc;
    logic [DATA_W-1:0]         fifo_wdata;

    modport master (
        output req,
        output wdata,
        output fifo_full,
        input  gnt,
        input  fifo_inc,
        input  fifo_wdata
    );

    modport slave (
        input  req,
        input  wdata,
        input  fifo_full,
        output gnt,
        output fifo_inc,
        output fifo_wdata
    );

endinterface

// File: rtl/a_fifo_wr_arb_rr_pick.sv
// Rotating-priority encoder: returns the first requester with req set,
// searching from rr_ptr upward and wrapping modulo NUM_REQ.
//   req    : request vector
//   rr_ptr : highest-priority index (must be < NUM_REQ)
//   valid  : any request present
//   idx    : chosen requester
// The request vector is duplicated side by side; masking off bits below
// rr_ptr and taking the lowest remaining set bit gives the wrapped search
// without a variable rotate.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] masked;
    logic                 found;

    always_comb begin
        dbl_req = {req, req};
        masked  = dbl_req & ({(2*NUM_REQ){1'b1}} << rr_ptr);
        valid   = |req;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                idx   = (i >= NUM_REQ) ? IDX_W'(i - NUM_REQ) : IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/a_fifo_wr_arb.sv
// Round-robin write-port arbiter in front of the async FIFO write-side
// pointer controller. Shares the single FIFO write port among NUM_REQ
// producers, granting bursts of up to BURST_LEN beats and honouring
// fifo_full back-pressure.
//   clk   : write-domain clock
//   rst   : synchronous reset, active-high
//   clear : synchronous soft clear, same effect as rst
//   bus   : slave side of a_fifo_wr_arb_if (req/wdata/gnt/fifo_* signals)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner, gnt=0, waiting for any req
// ST_BURST | owner holds the write port; beats move while req & ~full
module a_fifo_wr_arb
    import a_fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    a_fifo_wr_arb_if.slave bus
);

    localparam int IDX_W = width_min1(NUM_REQ);
    localparam int CNT_W = width_min1(BURST_LEN);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;

    logic               req_owner;
    logic               xfer;
    logic               end_burst;
    logic [IDX_W-1:0]   owner_plus1;
    logic [IDX_W-1:0]   pick_ptr;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    // Owner-indexed request and data selection. Loops instead of a
    // variable part-select keep the outputs defined for any owner value.
    always_comb begin
        req_owner      = 1'b0;
        bus.fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                req_owner      = bus.req[i];
                bus.fifo_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_plus1 = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    // In BURST the next pick starts just past the current owner so the old
    // owner is searched last; in IDLE it starts at the stored rr_ptr.
    assign pick_ptr = (state == ST_BURST) ? owner_plus1 : rr_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (pick_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign xfer         = (state == ST_BURST) && req_owner && !bus.fifo_full;
    assign bus.fifo_inc = xfer && !rst && !clear;
    assign end_burst    = (xfer && (burst_cnt == CNT_W'(BURST_LEN - 1))) ||
                          ((state == ST_BURST) && !req_owner);
    assign bus.gnt      = gnt_q;

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
                if (end_burst) begin
                    rr_ptr_nxt = owner_plus1;
                    if (pick_valid) begin
                        owner_nxt     = pick_idx;
                        burst_cnt_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        gnt_nxt = (state_nxt == ST_BURST) ? (NUM_REQ'(1) << owner_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            gnt_q     <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_a_fifo_wr_arb.sv
module tb_a_fifo_wr_arb;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;

    logic clk;
    logic rst;
    logic clear;
    int   checks;
    int   failures;

    a_fifo_wr_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    a_fifo_wr_arb #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int o);
        return 32'h1111_1111 * (o + 1);
    endfunction

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        clear         = 1'b0;
        bus.req       = 4'b1111;
        bus.fifo_full = 1'b0;
        bus.wdata     = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        // reset held two clocks with all requests high
        tick();
        chk("rst_gnt_a", {28'd0, bus.gnt}, 32'h0);
        chk("rst_inc_a", {31'd0, bus.fifo_inc}, 32'h0);
        tick();
        chk("rst_gnt_b", {28'd0, bus.gnt}, 32'h0);
        chk("rst_inc_b", {31'd0, bus.fifo_inc}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_gnt_idle", {28'd0, bus.gnt}, 32'h0);
        tick();

        // all requesting: four beats each, grants 0,1,2,3 then 0, no bubble
        for (int o = 0; o < NUM_REQ; o++) begin
            for (int b = 0; b < BURST_LEN; b++) begin
                #1;
                chk($sformatf("rr_gnt_o%0d_b%0d", o, b), {28'd0, bus.gnt}, 32'(1 << o));
                chk($sformatf("rr_inc_o%0d_b%0d", o, b), {31'd0, bus.fifo_inc}, 32'h1);
                chk($sformatf("rr_dat_o%0d_b%0d", o, b), bus.fifo_wdata, dat(o));
                tick();
            end
        end
        #1;
        chk("rr_wrap_gnt", {28'd0, bus.gnt}, 32'h1);

        // only requester 3: owner 0 drops, handoff to 3, then wrap to 0
        bus.req = 4'b1000;
        #1;
        chk("drop0_inc", {31'd0, bus.fifo_inc}, 32'h0);
        chk("drop0_gnt", {28'd0, bus.gnt}, 32'h1);
        tick();
        for (int b = 0; b < BURST_LEN; b++) begin
            if (b == BURST_LEN - 1) bus.req = 4'b1001;
            #1;
            chk($sformatf("r3_gnt_b%0d", b), {28'd0, bus.gnt}, 32'h8);
            chk($sformatf("r3_inc_b%0d", b), {31'd0, bus.fifo_inc}, 32'h1);
            chk($sformatf("r3_dat_b%0d", b), bus.fifo_wdata, dat(3));
            tick();
        end
        #1;
        chk("wrap_to0_gnt", {28'd0, bus.gnt}, 32'h1);

        // fifo_full stall for three clocks mid-burst
        bus.req = 4'b0011;
        #1;
        chk("full_b0_inc", {31'd0, bus.fifo_inc}, 32'h1);
        tick();
        #1;
        chk("full_b1_inc", {31'd0, bus.fifo_inc}, 32'h1);
        tick();
        bus.fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall%0d_inc", s), {31'd0, bus.fifo_inc}, 32'h0);
            chk($sformatf("stall%0d_gnt", s), {28'd0, bus.gnt}, 32'h1);
            tick();
        end
        bus.fifo_full = 1'b0;
        #1;
        chk("full_b2_inc", {31'd0, bus.fifo_inc}, 32'h1);
        chk("full_b2_gnt", {28'd0, bus.gnt}, 32'h1);
        tick();
        #1;
        chk("full_b3_inc", {31'd0, bus.fifo_inc}, 32'h1);
        chk("full_b3_gnt", {28'd0, bus.gnt}, 32'h1);
        tick();
        #1;
        chk("full_after_gnt", {28'd0, bus.gnt}, 32'h2);

        // owner 1 drops after two beats, others pending
        bus.req = 4'b0111;
        #1;
        chk("early_b0_inc", {31'd0, bus.fifo_inc}, 32'h1);
        chk("early_b0_dat", bus.fifo_wdata, dat(1));
        tick();
        #1;
        chk("early_b1_inc", {31'd0, bus.fifo_inc}, 32'h1);
        tick();
        bus.req = 4'b0101;
        #1;
        chk("early_drop_inc", {31'd0, bus.fifo_inc}, 32'h0);
        chk("early_drop_gnt", {28'd0, bus.gnt}, 32'h2);
        tick();
        #1;
        chk("early_hand_gnt", {28'd0, bus.gnt}, 32'h4);
        chk("early_hand_inc", {31'd0, bus.fifo_inc}, 32'h1);
        chk("early_hand_dat", bus.fifo_wdata, dat(2));
        tick();

        // soft clear mid-burst
        clear = 1'b1;
        #1;
        chk("clr_inc", {31'd0, bus.fifo_inc}, 32'h0);
        tick();
        clear = 1'b0;
        #1;
        chk("clr_gnt", {28'd0, bus.gnt}, 32'h0);
        chk("clr_idle_inc", {31'd0, bus.fifo_inc}, 32'h0);
        tick();
        #1;
        chk("clr_rearb_gnt", {28'd0, bus.gnt}, 32'h1);
        chk("clr_rearb_dat", bus.fifo_wdata, dat(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
